cpu_bus_responder: RTL
======================

// Module: cpu_bus_responder
// PURPOSE
//   Target end of the CPU memory bus. Answers the CPU's per-M-cycle read/write accesses, which are
//   sequenced by t_phase T1..T4. Serves HRAM (FF80-FFFE), IF (FF0F) and IE (FFFF) internally.
//   Forwards every other address to an external req/ack port and stalls the CPU in T3 until answered.
//   Owns interrupt flag state: peripherals set IF bits, the CPU acks them, and int_pending feeds the IME logic.
// PARAMETERS
//   WAIT_TIMEOUT  255  max cycles in T3 stall before the external access is abandoned (1..255)
// PORTS
//   clk          in   1   system clock, all state on rising edge
//   reset        in   1   synchronous, active-high
//   t_phase      in   2   cpu_types_pkg::t_phase_t, CPU T-state of current cycle
//   cpu_addr     in   16  access address, valid in T1
//   cpu_wdata    in   8   write data, valid T1..T4
//   cpu_rd       in   1   read request, sampled in T1 only
//   cpu_wr       in   1   write request, sampled in T1 only
//   cpu_rdata    out  8   read data, valid from T3 until next T1 latch
//   cpu_wait     out  1   CPU holds T3 while high
//   ext_req      out  1   external access request
//   ext_we       out  1   external access is write
//   ext_addr     out  16  external address (latched)
//   ext_wdata    out  8   external write data (latched)
//   ext_rdata    in   8   external read data, valid with ext_ack
//   ext_ack      in   1   one-cycle completion strobe
//   irq_set      in   5   per-bit IF set strobes (VBlank,STAT,Timer,Serial,Joypad)
//   int_ack      in   5   per-bit IF clear strobes from CPU interrupt dispatch
//   int_pending  out  5   IE[4:0] & IF[4:0], registered
//   bus_err      out  1   sticky: external timeout occurred; cleared by reset only
// BEHAVIOUR
//   Reset values: cpu_rdata=8'hFF, cpu_wait=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0,
//     int_pending=0, bus_err=0, IF=0, IE=0, FSM=IDLE. HRAM contents are not cleared.
//   Reset mid-access: FSM to IDLE and ext_req dropped on the same edge; a late ext_ack is ignored.
//   FSM: IDLE, INT_ACC, EXT_WAIT, EXT_DONE.
//   IDLE: on t_phase==T1 with cpu_rd|cpu_wr, latch addr/wdata/dir.
//     - cpu_rd & cpu_wr both high: treated as a write.
//     - Decode FF80-FFFE, FF0F or FFFF: go to INT_ACC.
//     - Any other address: go to EXT_WAIT, ext_req=1 from next cycle (T2).
//   INT_ACC:
//     - Read: cpu_rdata updated at the T2->T3 edge.
//       IF reads as {3'b111,IF}; IE reads all 8 bits; HRAM reads the addressed byte.
//     - Write: committed at T4 edge. IF stores wdata[4:0]; IE stores 8 bits.
//     - Return to IDLE after T4.
//   EXT_WAIT: ext_req held high with stable addr/we/wdata until ext_ack.
//     - ext_ack: ext_req low next cycle; read data latched into cpu_rdata; go to EXT_DONE.
//     - cpu_wait = (state==EXT_WAIT) && t_phase==T3 && !ext_ack (combinational).
//       An ack in T2 therefore produces no stall.
//     - Stall counter counts cycles with cpu_wait high, starting at 0.
//       On reaching WAIT_TIMEOUT: drop ext_req, cpu_rdata=8'hFF, bus_err=1, go to EXT_DONE.
//   EXT_DONE: go to IDLE after T4.
//   A T1 with no rd/wr leaves the FSM in IDLE; cpu_rdata holds its last value.
//   IF next-state per bit:
//     IF' = ((cpu IF write at T4) ? wdata : IF) & ~int_ack | irq_set
//     Set wins over ack and over a CPU write of 0.
//   int_pending is registered from the post-update IF/IE: 1-cycle latency after irq_set.
// TESTING
//   Reset, then write 8'h5A to FF80 and read it back -> cpu_rdata=8'h5A at T3, cpu_wait never high.
//   Write 8'h1F to FFFF; pulse irq_set=5'b00100 -> IF reads 8'hE4, int_pending=5'b00100 one cycle later.
//   Same cycle irq_set[0]=1 and int_ack[0]=1 with IF[0]=1 -> IF[0] stays 1.
//   Read C000, ext_ack with ext_rdata=8'h3C three cycles into T3 -> cpu_wait high exactly 3 cycles,
//     cpu_rdata=8'h3C.
//   Read C000 with WAIT_TIMEOUT=4 and no ack -> cpu_wait high 4 cycles, cpu_rdata=8'hFF,
//     bus_err=1, ext_req=0.
//   Assert reset during EXT_WAIT, then ack on the next cycle -> ext_req=0, FSM IDLE, cpu_rdata=8'hFF.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// CPU memory-bus target: internal HRAM/IF/IE, external req/ack forwarding
// with T3 stall and timeout, and interrupt flag bookkeeping.

package cpu_types_pkg;
    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } t_phase_t;
endpackage

// state    | meaning
// IDLE     | waiting for a T1 with rd/wr
// INT_ACC  | internal HRAM/IF/IE access in progress
// EXT_WAIT | external request outstanding, stalling the CPU in T3
// EXT_DONE | external access finished (acked or timed out), wait for T4
module cpu_bus_responder
    import cpu_types_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  t_phase_t    t_phase,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    input  logic [4:0]  irq_set,
    input  logic [4:0]  int_ack,
    output logic [4:0]  int_pending,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, INT_ACC, EXT_WAIT, EXT_DONE} state_t;

    // Last stall cycle before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic [7:0]  stall_cnt;
    logic [4:0]  if_q, if_next;
    logic [7:0]  ie_q, ie_next;
    logic [7:0]  hram [0:127];

    logic req, is_int, latch, ack_hit, timeout;
    logic sel_hram, sel_if, sel_ie, int_rd, int_wr;

    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;
    assign ext_we    = we_q;

    assign req      = (t_phase == T1) && (cpu_rd || cpu_wr);
    assign is_int   = (cpu_addr[15:7] == 9'h1FF) || (cpu_addr == 16'hFF0F);
    assign sel_ie   = (addr_q == 16'hFFFF);
    assign sel_if   = (addr_q == 16'hFF0F);
    assign sel_hram = (addr_q[15:7] == 9'h1FF) && !sel_ie;
    assign int_rd   = (state == INT_ACC) && (t_phase == T2) && !we_q;
    assign int_wr   = (state == INT_ACC) && (t_phase == T4) && we_q;

    // Interrupt flags: set strobes dominate both ack and a CPU write of 0.
    assign if_next = (((int_wr && sel_if) ? wdata_q[4:0] : if_q) & ~int_ack) | irq_set;
    assign ie_next = (int_wr && sel_ie) ? wdata_q : ie_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode, stall output and one-cycle event strobes.
    always_comb begin
        state_next = state;
        cpu_wait   = 1'b0;
        latch      = 1'b0;
        ack_hit    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch      = 1'b1;
                    state_next = is_int ? INT_ACC : EXT_WAIT;
                end
            end
            INT_ACC: begin
                if (t_phase == T4) state_next = IDLE;
            end
            EXT_WAIT: begin
                cpu_wait = (t_phase == T3) && !ext_ack;
                if (ext_ack) begin
                    ack_hit    = 1'b1;
                    state_next = EXT_DONE;
                end else if (cpu_wait && (stall_cnt == TO_LAST)) begin
                    timeout    = 1'b1;
                    state_next = EXT_DONE;
                end
            end
            EXT_DONE: begin
                if (t_phase == T4) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Access latch, read data, external handshake, stall timer and IF/IE.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            ext_req     <= 1'b0;
            cpu_rdata   <= 8'hFF;
            stall_cnt   <= 8'h00;
            bus_err     <= 1'b0;
            if_q        <= 5'h00;
            ie_q        <= 8'h00;
            int_pending <= 5'h00;
        end else begin
            if (latch) begin
                addr_q    <= cpu_addr;
                wdata_q   <= cpu_wdata;
                we_q      <= cpu_wr;
                stall_cnt <= 8'h00;
                ext_req   <= !is_int;
            end
            if (int_rd) begin
                if (sel_if)      cpu_rdata <= {3'b111, if_q};
                else if (sel_ie) cpu_rdata <= ie_q;
                else             cpu_rdata <= hram[addr_q[6:0]];
            end
            if (ack_hit) begin
                ext_req <= 1'b0;
                if (!we_q) cpu_rdata <= ext_rdata;
            end else if (timeout) begin
                ext_req   <= 1'b0;
                cpu_rdata <= 8'hFF;
                bus_err   <= 1'b1;
            end else if (cpu_wait) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            if_q        <= if_next;
            ie_q        <= ie_next;
            int_pending <= ie_next[4:0] & if_next;
        end
    end

    // HRAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (int_wr && sel_hram) hram[addr_q[6:0]] <= wdata_q;
    end

endmodule
